// File: rtl/ahblite_master_arb.sv
// rtl/ahblite_master_arb.sv - two-master to one-slave AHB-Lite arbiter with per-master replay buffers
module ahblite_master_arb #(
    parameter int AW = 32,
    parameter int DW = 64
) (
    input  logic          HCLK,
    input  logic          HRESETn,

    input  logic [AW-1:0] M0_HADDR,
    input  logic [1:0]    M0_HTRANS,
    input  logic          M0_HWRITE,
    input  logic [2:0]    M0_HSIZE,
    input  logic [DW-1:0] M0_HWDATA,
    output logic          M0_HREADY,
    output logic [DW-1:0] M0_HRDATA,
    output logic          M0_HRESP,

    input  logic [AW-1:0] M1_HADDR,
    input  logic [1:0]    M1_HTRANS,
    input  logic          M1_HWRITE,
    input  logic [2:0]    M1_HSIZE,
    input  logic [DW-1:0] M1_HWDATA,
    output logic          M1_HREADY,
    output logic [DW-1:0] M1_HRDATA,
    output logic          M1_HRESP,

    output logic [AW-1:0] S_HADDR,
    output logic [1:0]    S_HTRANS,
    output logic          S_HWRITE,
    output logic [2:0]    S_HSIZE,
    output logic [DW-1:0] S_HWDATA,
    input  logic          S_HREADY,
    input  logic [DW-1:0] S_HRDATA
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    logic [1:0]    pend_valid;
    logic [AW-1:0] pend_addr  [2];
    logic          pend_write [2];
    logic [2:0]    pend_size  [2];

    logic          dph_valid;
    logic          dph_owner;
    logic          last_grant;

    logic [AW-1:0] live_addr  [2];
    logic          live_write [2];
    logic [2:0]    live_size  [2];
    logic [1:0]    hready;
    logic [1:0]    live;
    logic [1:0]    cand;

    logic          gnt;
    logic          issue;
    logic [AW-1:0] gnt_addr;
    logic          gnt_write;
    logic [2:0]    gnt_size;

    assign live_addr[0]  = M0_HADDR;
    assign live_addr[1]  = M1_HADDR;
    assign live_write[0] = M0_HWRITE;
    assign live_write[1] = M1_HWRITE;
    assign live_size[0]  = M0_HSIZE;
    assign live_size[1]  = M1_HSIZE;

    // The data-phase owner follows the slave; a master with a buffered request is held off.
    assign hready[0] = (dph_valid && !dph_owner) ? S_HREADY : !pend_valid[0];
    assign hready[1] = (dph_valid &&  dph_owner) ? S_HREADY : !pend_valid[1];

    // BUSY/IDLE carry no request; SEQ is treated like NONSEQ.
    assign live[0] = hready[0] && (M0_HTRANS == TRANS_NONSEQ || M0_HTRANS == TRANS_SEQ);
    assign live[1] = hready[1] && (M1_HTRANS == TRANS_NONSEQ || M1_HTRANS == TRANS_SEQ);

    assign cand = pend_valid | live;

    always_comb begin
        gnt = 1'b0;
        if (cand == 2'b11) begin
            gnt = !last_grant;
        end else begin
            gnt = cand[1];
        end
    end

    assign issue     = (cand != 2'b00) && S_HREADY;
    assign gnt_addr  = pend_valid[gnt] ? pend_addr[gnt]  : live_addr[gnt];
    assign gnt_write = pend_valid[gnt] ? pend_write[gnt] : live_write[gnt];
    assign gnt_size  = pend_valid[gnt] ? pend_size[gnt]  : live_size[gnt];

    // The address phase is only shown to the slave in a cycle where it can be accepted.
    assign S_HTRANS = issue ? TRANS_NONSEQ : TRANS_IDLE;
    assign S_HADDR  = issue ? gnt_addr  : '0;
    assign S_HWRITE = issue ? gnt_write : 1'b0;
    assign S_HSIZE  = issue ? gnt_size  : 3'b000;
    assign S_HWDATA = !dph_valid ? '0 : (dph_owner ? M1_HWDATA : M0_HWDATA);

    assign M0_HREADY = hready[0];
    assign M1_HREADY = hready[1];
    assign M0_HRDATA = S_HRDATA;
    assign M1_HRDATA = S_HRDATA;
    assign M0_HRESP  = 1'b0;
    assign M1_HRESP  = 1'b0;

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            pend_valid <= 2'b00;
            dph_valid  <= 1'b0;
            dph_owner  <= 1'b0;
            last_grant <= 1'b1;
            for (int i = 0; i < 2; i++) begin
                pend_addr[i]  <= '0;
                pend_write[i] <= 1'b0;
                pend_size[i]  <= 3'b000;
            end
        end else begin
            if (issue) begin
                dph_valid  <= 1'b1;
                dph_owner  <= gnt;
                last_grant <= gnt;
                if (pend_valid[gnt]) begin
                    pend_valid[gnt] <= 1'b0;
                end
            end else if (S_HREADY) begin
                dph_valid <= 1'b0;
            end

            // A live request not taken this cycle is kept for replay.
            for (int i = 0; i < 2; i++) begin
                if (live[i] && !(issue && gnt == 1'(i))) begin
                    pend_valid[i] <= 1'b1;
                    pend_addr[i]  <= live_addr[i];
                    pend_write[i] <= live_write[i];
                    pend_size[i]  <= live_size[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_ahblite_master_arb.sv
// tb/tb_ahblite_master_arb.sv - directed self-checking bench for ahblite_master_arb
module tb_ahblite_master_arb;

    logic        HCLK;
    logic        HRESETn;
    logic [31:0] M0_HADDR, M1_HADDR, S_HADDR;
    logic [1:0]  M0_HTRANS, M1_HTRANS, S_HTRANS;
    logic        M0_HWRITE, M1_HWRITE, S_HWRITE;
    logic [2:0]  M0_HSIZE, M1_HSIZE, S_HSIZE;
    logic [63:0] M0_HWDATA, M1_HWDATA, S_HWDATA;
    logic        M0_HREADY, M1_HREADY, S_HREADY;
    logic [63:0] M0_HRDATA, M1_HRDATA, S_HRDATA;
    logic        M0_HRESP, M1_HRESP;

    int checks = 0;
    int errors = 0;

    ahblite_master_arb #(.AW(32), .DW(64)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HWRITE(M0_HWRITE), .M0_HSIZE(M0_HSIZE),
        .M0_HWDATA(M0_HWDATA), .M0_HREADY(M0_HREADY), .M0_HRDATA(M0_HRDATA), .M0_HRESP(M0_HRESP),
        .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HWRITE(M1_HWRITE), .M1_HSIZE(M1_HSIZE),
        .M1_HWDATA(M1_HWDATA), .M1_HREADY(M1_HREADY), .M1_HRDATA(M1_HRDATA), .M1_HRESP(M1_HRESP),
        .S_HADDR(S_HADDR), .S_HTRANS(S_HTRANS), .S_HWRITE(S_HWRITE), .S_HSIZE(S_HSIZE),
        .S_HWDATA(S_HWDATA), .S_HREADY(S_HREADY), .S_HRDATA(S_HRDATA)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle_all();
        M0_HTRANS = 2'b00; M1_HTRANS = 2'b00;
        M0_HWRITE = 1'b0;  M1_HWRITE = 1'b0;
        M0_HSIZE  = 3'd3;  M1_HSIZE  = 3'd3;
        S_HREADY  = 1'b1;
    endtask

    task automatic do_reset();
        idle_all();
        HRESETn = 1'b0;
        tick();
        HRESETn = 1'b1;
    endtask

    task automatic test_reset();
        idle_all();
        M0_HADDR = 32'h0; M1_HADDR = 32'h0;
        M0_HWDATA = 64'hAAAA_0000_0000_0001; M1_HWDATA = 64'hBBBB_0000_0000_0002;
        S_HRDATA = 64'h0;
        HRESETn = 1'b0;
        tick(); tick();
        HRESETn = 1'b1;
        #2;
        checks++; if (S_HTRANS !== 2'b00) begin errors++; $display("FAIL reset_htrans got %h exp 0", S_HTRANS); end
        checks++; if (M0_HREADY !== 1'b1 || M1_HREADY !== 1'b1) begin errors++; $display("FAIL reset_hready got %b%b exp 11", M0_HREADY, M1_HREADY); end
        checks++; if (S_HWDATA !== 64'h0) begin errors++; $display("FAIL reset_hwdata got %h exp 0", S_HWDATA); end
        checks++; if (M0_HRESP !== 1'b0 || M1_HRESP !== 1'b0) begin errors++; $display("FAIL reset_hresp got %b%b exp 00", M0_HRESP, M1_HRESP); end
        tick();
    endtask

    task automatic test_lone_read();
        M0_HADDR = 32'h0000_1000; M0_HTRANS = 2'b10; M0_HWRITE = 1'b0; S_HREADY = 1'b1;
        #2;
        checks++; if (S_HTRANS !== 2'b10) begin errors++; $display("FAIL lone_htrans got %h exp 2", S_HTRANS); end
        checks++; if (S_HADDR !== 32'h0000_1000) begin errors++; $display("FAIL lone_haddr got %h exp 1000", S_HADDR); end
        checks++; if (S_HWRITE !== 1'b0 || S_HSIZE !== 3'd3) begin errors++; $display("FAIL lone_ctrl got w%b s%0d exp w0 s3", S_HWRITE, S_HSIZE); end
        tick();
        M0_HTRANS = 2'b00; S_HRDATA = 64'hDEAD_BEEF_0123_4567;
        #2;
        checks++; if (M0_HRDATA !== 64'hDEAD_BEEF_0123_4567) begin errors++; $display("FAIL lone_hrdata got %h exp deadbeef01234567", M0_HRDATA); end
        checks++; if (M0_HREADY !== 1'b1) begin errors++; $display("FAIL lone_hready got %b exp 1", M0_HREADY); end
        checks++; if (S_HTRANS !== 2'b00) begin errors++; $display("FAIL lone_idle got %h exp 0", S_HTRANS); end
        tick();
    endtask

    task automatic test_simultaneous();
        do_reset();
        M0_HADDR = 32'h0000_0100; M0_HTRANS = 2'b10; M0_HWRITE = 1'b0;
        M1_HADDR = 32'h2000_0008; M1_HTRANS = 2'b10; M1_HWRITE = 1'b1;
        #2;
        checks++; if (S_HADDR !== 32'h0000_0100 || S_HWRITE !== 1'b0) begin errors++; $display("FAIL sim_first got %h w%b exp 100 w0", S_HADDR, S_HWRITE); end
        tick();
        M0_HTRANS = 2'b00; M1_HTRANS = 2'b00; M1_HWDATA = 64'h1122_3344_5566_7788;
        #2;
        checks++; if (M1_HREADY !== 1'b0) begin errors++; $display("FAIL sim_m1_held got %b exp 0", M1_HREADY); end
        checks++; if (S_HTRANS !== 2'b10 || S_HADDR !== 32'h2000_0008 || S_HWRITE !== 1'b1) begin errors++; $display("FAIL sim_second got %h %h w%b exp 2 20000008 w1", S_HTRANS, S_HADDR, S_HWRITE); end
        checks++; if (M0_HREADY !== 1'b1) begin errors++; $display("FAIL sim_m0_dph got %b exp 1", M0_HREADY); end
        tick();
        #2;
        checks++; if (S_HWDATA !== 64'h1122_3344_5566_7788) begin errors++; $display("FAIL sim_hwdata got %h exp 1122334455667788", S_HWDATA); end
        checks++; if (M1_HREADY !== 1'b1 || S_HTRANS !== 2'b00) begin errors++; $display("FAIL sim_m1_done got %b %h exp 1 0", M1_HREADY, S_HTRANS); end
        tick();
        #2;
        checks++; if (S_HWDATA !== 64'h0) begin errors++; $display("FAIL sim_hwdata_clear got %h exp 0", S_HWDATA); end
        tick();
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_addr [7];
        exp_addr = '{32'hA00, 32'hB00, 32'hA00, 32'hB00, 32'hA00, 32'hB00, 32'hA00};
        do_reset();
        M0_HADDR = 32'h0000_0A00; M1_HADDR = 32'h0000_0B00;
        M0_HWRITE = 1'b0; M1_HWRITE = 1'b0;
        for (int c = 0; c < 7; c++) begin
            M0_HTRANS = (c < 6) ? 2'b10 : 2'b00;
            M1_HTRANS = (c < 6) ? 2'b10 : 2'b00;
            #2;
            checks++;
            if (S_HTRANS !== 2'b10 || S_HADDR !== exp_addr[c]) begin
                errors++; $display("FAIL rr_cycle%0d got %h %h exp 2 %h", c, S_HTRANS, S_HADDR, exp_addr[c]);
            end
            tick();
        end
        idle_all();
        #2;
        checks++; if (S_HTRANS !== 2'b00) begin errors++; $display("FAIL rr_drain got %h exp 0", S_HTRANS); end
        tick(); tick();
    endtask

    task automatic test_stall();
        M1_HADDR = 32'h0000_3000; M1_HTRANS = 2'b10; S_HREADY = 1'b1;
        #2;
        checks++; if (S_HADDR !== 32'h0000_3000 || S_HTRANS !== 2'b10) begin errors++; $display("FAIL stall_m1_issue got %h %h exp 3000 2", S_HADDR, S_HTRANS); end
        tick();
        M1_HTRANS = 2'b00; S_HREADY = 1'b0;
        M0_HADDR = 32'h0000_4000; M0_HTRANS = 2'b10;
        #2;
        checks++; if (S_HTRANS !== 2'b00 || M1_HREADY !== 1'b0 || M0_HREADY !== 1'b1) begin errors++; $display("FAIL stall_c1 got %h r1%b r0%b exp 0 0 1", S_HTRANS, M1_HREADY, M0_HREADY); end
        tick();
        M0_HTRANS = 2'b00;
        #2;
        checks++; if (S_HTRANS !== 2'b00 || M0_HREADY !== 1'b0) begin errors++; $display("FAIL stall_c2 got %h r0%b exp 0 0", S_HTRANS, M0_HREADY); end
        tick();
        #2;
        checks++; if (S_HTRANS !== 2'b00 || M1_HREADY !== 1'b0) begin errors++; $display("FAIL stall_c3 got %h r1%b exp 0 0", S_HTRANS, M1_HREADY); end
        tick();
        S_HREADY = 1'b1; S_HRDATA = 64'h0BAD_F00D_CAFE_0001;
        #2;
        checks++; if (S_HTRANS !== 2'b10 || S_HADDR !== 32'h0000_4000) begin errors++; $display("FAIL stall_m0_issue got %h %h exp 2 4000", S_HTRANS, S_HADDR); end
        checks++; if (M1_HREADY !== 1'b1 || M1_HRDATA !== 64'h0BAD_F00D_CAFE_0001) begin errors++; $display("FAIL stall_m1_done got %b %h exp 1 0badf00dcafe0001", M1_HREADY, M1_HRDATA); end
        tick();
        #2;
        checks++; if (M0_HREADY !== 1'b1 || S_HTRANS !== 2'b00) begin errors++; $display("FAIL stall_m0_done got %b %h exp 1 0", M0_HREADY, S_HTRANS); end
        tick();
    endtask

    task automatic test_seq_busy();
        logic [1:0]  tr  [3];
        logic [1:0]  exp [3];
        logic [31:0] ad  [3];
        tr  = '{2'b10, 2'b01, 2'b11};
        exp = '{2'b10, 2'b00, 2'b10};
        ad  = '{32'h5000, 32'h5008, 32'h5008};
        idle_all();
        for (int c = 0; c < 3; c++) begin
            M0_HTRANS = tr[c]; M0_HADDR = ad[c];
            #2;
            checks++;
            if (S_HTRANS !== exp[c] || (exp[c] == 2'b10 && S_HADDR !== ad[c])) begin
                errors++; $display("FAIL seqbusy_cycle%0d got %h %h exp %h %h", c, S_HTRANS, S_HADDR, exp[c], ad[c]);
            end
            tick();
        end
        idle_all();
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        M0_HADDR = 32'h0000_6000; M0_HTRANS = 2'b10;
        M1_HADDR = 32'h0000_7000; M1_HTRANS = 2'b10; M1_HWRITE = 1'b1;
        tick();
        idle_all();
        HRESETn = 1'b0;
        #2;
        checks++; if (M1_HREADY !== 1'b0) begin errors++; $display("FAIL rstmid_pend got %b exp 0", M1_HREADY); end
        tick();
        HRESETn = 1'b1;
        #2;
        checks++; if (S_HTRANS !== 2'b00 || M0_HREADY !== 1'b1 || M1_HREADY !== 1'b1) begin errors++; $display("FAIL rstmid_after got %h r0%b r1%b exp 0 1 1", S_HTRANS, M0_HREADY, M1_HREADY); end
        checks++; if (S_HWDATA !== 64'h0) begin errors++; $display("FAIL rstmid_hwdata got %h exp 0", S_HWDATA); end
        tick();
        #2;
        checks++; if (S_HTRANS !== 2'b00) begin errors++; $display("FAIL rstmid_noreplay got %h exp 0", S_HTRANS); end
        tick();
    endtask

    initial begin
        test_reset();
        test_lone_read();
        test_simultaneous();
        test_round_robin();
        test_stall();
        test_seq_busy();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
